// File: rtl/shift_register_tx_ctrl_if.sv
// Byte stream handshake between a producer and the shift register sequencer.
// Master is the byte source; slave is the sequencing controller.
interface shift_register_tx_ctrl_if;
   logic       i_valid;
   logic [7:0] i_data;
   logic       o_ready;

   modport master (
      output i_valid,
      output i_data,
      input  o_ready
   );

   modport slave (
      input  i_valid,
      input  i_data,
      output o_ready
   );
endinterface

// File: rtl/shift_register_tx_ctrl.sv
// Load/shift sequencer for an 8-bit enable-less shift register.
// Frames each byte into 8 strobed serial bits with optional idle gaps.
module shift_register_tx_ctrl #(
   parameter bit          LSB_FIRST = 1'b0,
   parameter bit          FILL      = 1'b0,
   parameter int unsigned GAP       = 0
) (
   input  logic                           i_clk,
   input  logic                           i_rstn,
   shift_register_tx_ctrl_if.slave        bus,
   input  logic                           i_abort,
   output logic                           o_sr_load,
   output logic [7:0]                     o_sr_par,
   output logic                           o_sr_ser_in,
   output logic                           o_bit_valid,
   output logic                           o_bit_last,
   output logic                           o_busy,
   output logic [15:0]                    o_frame_cnt
);

   localparam bit         NO_GAP = (GAP == 0);
   localparam logic [3:0] GAP_M1 = NO_GAP ? 4'd0 : 4'(GAP - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_GAP
   } state_t;

   state_t      state;
   logic [2:0]  cnt;
   logic [3:0]  gcnt;
   logic [15:0] frame_cnt;
   logic        bit_valid;
   logic        bit_last;
   logic        busy;

   logic        last_bit;
   logic        ready;
   logic        load;
   logic [7:0]  data_rev;

   assign last_bit = (state == ST_SHIFT) && (cnt == 3'd7);

   // A reload is only possible on the final bit when no gap is configured
   assign ready = !i_abort &&
                  ((state == ST_IDLE) || (last_bit && NO_GAP));
   assign load  = bus.i_valid && ready;

   always_comb begin
      data_rev = 8'h00;
      for (int i = 0; i < 8; i++) begin
         data_rev[i] = bus.i_data[7-i];
      end
   end

   assign bus.o_ready  = ready;
   assign o_sr_load    = load;
   assign o_sr_par     = LSB_FIRST ? data_rev : bus.i_data;
   assign o_sr_ser_in  = FILL;
   assign o_bit_valid  = bit_valid;
   assign o_bit_last   = bit_last;
   assign o_busy       = busy;
   assign o_frame_cnt  = frame_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state     <= ST_IDLE;
         cnt       <= 3'd0;
         gcnt      <= 4'd0;
         frame_cnt <= 16'd0;
         bit_valid <= 1'b0;
         bit_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load) begin
                  state     <= ST_SHIFT;
                  cnt       <= 3'd0;
                  bit_valid <= 1'b1;
                  bit_last  <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (i_abort) begin
                  state     <= ST_IDLE;
                  cnt       <= 3'd0;
                  bit_valid <= 1'b0;
                  bit_last  <= 1'b0;
                  busy      <= 1'b0;
               end else if (cnt == 3'd7) begin
                  frame_cnt <= frame_cnt + 16'd1;
                  bit_last  <= 1'b0;
                  cnt       <= 3'd0;
                  if (!NO_GAP) begin
                     state     <= ST_GAP;
                     gcnt      <= GAP_M1;
                     bit_valid <= 1'b0;
                     busy      <= 1'b1;
                  end else if (load) begin
                     state     <= ST_SHIFT;
                     bit_valid <= 1'b1;
                     busy      <= 1'b1;
                  end else begin
                     state     <= ST_IDLE;
                     bit_valid <= 1'b0;
                     busy      <= 1'b0;
                  end
               end else begin
                  cnt      <= cnt + 3'd1;
                  bit_last <= (cnt == 3'd6);
               end
            end
            ST_GAP: begin
               if (gcnt == 4'd0) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  gcnt <= gcnt - 4'd1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               bit_valid <= 1'b0;
               bit_last  <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
